// File: rtl/vga_mode_pkg.sv
// Shared types and helpers for the mode selector path into the VGA pipeline.
package vga_mode_pkg;

  localparam int MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_DEFAULT = 2'd1;

  typedef enum logic [1:0] {IDLE, ARMED, FLASH} mode_state_t;

  // A selection is legal when it lies in 1..num_modes; zero means "nothing selected".
  function automatic logic sel_valid(input logic [MODE_W-1:0] sel, input int num_modes);
    return (sel != '0) && (int'(sel) <= num_modes);
  endfunction

endpackage

// File: rtl/vga_mode_commit.sv
// Commits the selector's mode to the pixel pipeline only at frame boundaries,
// with a one-cycle change strobe and a frame-counted acknowledge LED.
module vga_mode_commit
  import vga_mode_pkg::*;
#(
  parameter int NUM_MODES    = 2,
  parameter int FLASH_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] sel_in,
  input  logic              frame_end,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic              busy,
  output logic              led_ack
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  mode_state_t       state, state_n;
  logic [MODE_W-1:0] pending, pending_n, mode_n;
  logic [CNT_W-1:0]  flash_cnt, flash_cnt_n;
  logic              led_n, chg_n, req;

  // A fresh request: legal and different from what is already on screen.
  assign req  = sel_valid(sel_in, NUM_MODES) && (sel_in != mode);
  assign busy = (state != IDLE);

  always_comb begin
    state_n     = state;
    pending_n   = pending;
    mode_n      = mode;
    flash_cnt_n = flash_cnt;
    led_n       = led_ack;
    chg_n       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          pending_n = sel_in;
          state_n   = ARMED;
        end
      end
      ARMED: begin
        // Withdrawal beats a coincident frame boundary.
        if (sel_in == mode) begin
          state_n = IDLE;
        end else if (frame_end) begin
          mode_n      = pending;
          chg_n       = 1'b1;
          led_n       = 1'b1;
          flash_cnt_n = '0;
          state_n     = FLASH;
        end else if (req) begin
          pending_n = sel_in;
        end
      end
      FLASH: begin
        // A new request abandons the flash, even on the terminal frame.
        if (req) begin
          pending_n   = sel_in;
          led_n       = 1'b0;
          flash_cnt_n = '0;
          state_n     = ARMED;
        end else if (frame_end) begin
          if (flash_cnt == CNT_LAST) begin
            led_n       = 1'b0;
            flash_cnt_n = '0;
            state_n     = IDLE;
          end else begin
            flash_cnt_n = flash_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= MODE_DEFAULT;
      mode         <= MODE_DEFAULT;
      flash_cnt    <= '0;
      led_ack      <= 1'b0;
      mode_changed <= 1'b0;
    end else begin
      state        <= state_n;
      pending      <= pending_n;
      mode         <= mode_n;
      flash_cnt    <= flash_cnt_n;
      led_ack      <= led_n;
      mode_changed <= chg_n;
    end
  end

endmodule

// File: tb/tb_vga_mode_commit.sv
// Scoreboarded bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares them after every clock edge.
module tb_vga_mode_commit;

  localparam int NM = 2;
  localparam int FF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sel_in = 2'd1;
  logic       frame_end = 1'b0;
  logic [1:0] mode;
  logic       mode_changed, busy, led_ack;

  vga_mode_commit #(.NUM_MODES(NM), .FLASH_FRAMES(FF)) dut (
    .clk(clk), .reset(reset), .sel_in(sel_in), .frame_end(frame_end),
    .mode(mode), .mode_changed(mode_changed), .busy(busy), .led_ack(led_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       chg;
    logic       busy;
    logic       led;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: what is shown, what is waiting, and how many frames of LED remain.
  int  m_mode = 1, m_pend = 1, m_left = 0;
  bit  m_waiting = 0, m_chg = 0;

  function automatic void model_step(input bit rst, input int sel, input bit fe);
    bit legal;
    legal = (sel >= 1) && (sel <= NM);
    m_chg = 0;
    if (rst) begin
      m_mode = 1; m_pend = 1; m_waiting = 0; m_left = 0;
    end else if (m_waiting) begin
      if (sel == m_mode) m_waiting = 0;
      else if (fe) begin
        m_mode = m_pend; m_chg = 1; m_waiting = 0; m_left = FF;
      end else if (legal) m_pend = sel;
    end else if (m_left > 0) begin
      if (legal && sel != m_mode) begin
        m_pend = sel; m_waiting = 1; m_left = 0;
      end else if (fe) m_left = m_left - 1;
    end else if (legal && sel != m_mode) begin
      m_pend = sel; m_waiting = 1;
    end
  endfunction

  task automatic cyc(input bit rst, input int sel, input bit fe);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; sel_in = 2'(sel); frame_end = fe;
    model_step(rst, sel, fe);
    e.mode = 2'(m_mode);
    e.chg  = m_chg;
    e.busy = m_waiting || (m_left > 0);
    e.led  = (m_left > 0);
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mode", int'(mode), int'(e.mode));
        chk("mode_changed", int'(mode_changed), int'(e.chg));
        chk("busy", int'(busy), int'(e.busy));
        chk("led_ack", int'(led_ack), int'(e.led));
      end
    end
  end

  task automatic frames(input int n, input int sel);
    for (int i = 0; i < n; i++) begin
      cyc(0, sel, 0); cyc(0, sel, 0); cyc(0, sel, 1);
    end
  endtask

  initial begin : stim
    int sel;
    // Reset with a live request and frame pulses, then request is armed on release.
    for (int i = 0; i < 3; i++) cyc(1, 2, 1);
    cyc(0, 2, 0);
    for (int i = 0; i < 8; i++) cyc(0, 2, 0);
    cyc(0, 2, 1);                 // commit
    frames(4, 2);                 // LED drops after third later frame_end
    // Withdrawal back to the committed mode.
    cyc(1, 1, 0);
    cyc(0, 2, 0); cyc(0, 2, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    // Invalid selections across frames.
    frames(2, 0); frames(2, 3);
    // Withdrawal coincident with frame_end.
    cyc(0, 2, 0); cyc(0, 2, 0); cyc(0, 1, 1); cyc(0, 1, 0);
    // New request on the terminal frame of a flash.
    cyc(0, 2, 0); cyc(0, 2, 1);
    frames(2, 2);
    cyc(0, 1, 1); cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 0);
    // Reset while armed, then while flashing.
    cyc(0, 2, 0); cyc(1, 2, 0); cyc(0, 1, 0);
    cyc(0, 2, 0); cyc(0, 2, 1); cyc(0, 2, 0); cyc(1, 2, 0); cyc(0, 1, 0);
    // Randomized traffic.
    sel = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) sel = $urandom_range(0, 3);
      cyc(($urandom_range(0, 299) == 0), sel, ($urandom_range(0, 4) == 0));
    end
    cyc(0, sel, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_mode_commit.md
# vga_mode_commit

Receiving end of the push-button selector path: takes the 2-bit mode selection produced by the debounced selector counter and commits it to the VGA pixel pipeline only at a frame boundary, so a mode switch never tears a frame. Each commit produces a one-cycle change strobe and a frame-counted acknowledge LED pulse. The block sits between the selector counter and the VGA pattern/colour generator, in the same clock domain as both.

## Interface
- NUM_MODES, 2: number of valid modes; legal selections are 1..NUM_MODES (max 3).
- FLASH_FRAMES, 30: number of frame_end pulses the acknowledge LED stays lit after a commit; must be ≥1.
- clk  input  1  system clock, shared with the selector counter and the VGA timing generator.
- reset  input  1  synchronous, active-high reset.
- sel_in  input  2  requested mode from the selector counter; values outside 1..NUM_MODES are ignored.
- frame_end  input  1  one-cycle pulse from VGA timing on the last pixel clock of each frame.
- mode  output  2  committed mode fed to the pattern generator; registered.
- mode_changed  output  1  one-cycle strobe in the first cycle a new mode value is presented.
- busy  output  1  high whenever the FSM is not IDLE.
- led_ack  output  1  acknowledge indicator; high for FLASH_FRAMES frames after each commit.

## Operation
- Reset values: mode=1, pending=1, mode_changed=0, led_ack=0, flash_cnt=0, state=IDLE, busy=0. Reset has priority over every other event and aborts any pending request; a request in flight at reset is discarded.
- FSM states: IDLE, ARMED, FLASH.
- IDLE: valid sel_in ≠ mode → pending<=sel_in, go to ARMED. frame_end is ignored. Invalid sel_in (0, or >NUM_MODES) → no action.
- ARMED: waiting for a frame boundary.
  - Valid sel_in ≠ mode and ≠ pending → pending<=sel_in; remain ARMED.
  - sel_in == mode (request withdrawn) → IDLE; no commit, no strobe.
  - frame_end=1 → mode<=pending, mode_changed<=1, led_ack<=1, flash_cnt<=0, go to FLASH. The pending register is committed. A sel_in change in the same cycle is evaluated on the next cycle as a fresh request.
  - Withdrawal and frame_end in the same cycle → withdrawal wins; return to IDLE.
- FLASH: led_ack held high. Each frame_end increments flash_cnt. On a frame_end with flash_cnt == FLASH_FRAMES-1 → led_ack<=0, flash_cnt<=0, go to IDLE.
  - Valid sel_in ≠ mode → pending<=sel_in, led_ack<=0, flash_cnt<=0, go to ARMED; the flash is abandoned.
  - If a new request and the terminal frame_end coincide, the request wins and the FSM goes to ARMED.
- mode_changed deasserts on the cycle after it asserts, regardless of state.
- flash_cnt width is $clog2(FLASH_FRAMES+1); the counter never wraps, because it is cleared on FLASH exit.

## Timing
- A request takes effect on the second cycle: sel_in valid at edge t → ARMED visible at t+1.
- frame_end is honoured only in ARMED. A request and frame_end arriving in the same IDLE cycle therefore wait for the following frame.
- Commit latency: frame_end sampled at edge f → mode and mode_changed updated at f+1. The new mode is therefore stable from the first pixel of the next frame.
- led_ack is high from f+1 through the edge after the FLASH_FRAMES-th subsequent frame_end.
- busy is decoded combinationally from the state register, with no added latency.

## Structure
- Package vga_mode_pkg holds:
  - MODE_W = 2
  - MODE_DEFAULT = 2'd1
  - typedef enum logic [1:0] {IDLE, ARMED, FLASH} mode_state_t
  - function sel_valid(sel, num_modes), shared with future consumers of the selector.
- No sub-module: a single always_ff for the FSM, pending register, mode and flash counter, plus one always_comb for next-state logic.

## Test plan
- Reset and idle: assert reset 3 cycles with sel_in=2 and frame_end pulsing. Required: mode=1, led_ack=0, busy=0 throughout reset. After release, ARMED on the next cycle.
- Basic commit: sel_in 1→2 at cycle 10, frame_end at cycle 50. Required: mode=1 until cycle 51, mode=2 and mode_changed=1 for exactly cycle 51, led_ack high. With FLASH_FRAMES=3, led_ack drops after the third later frame_end.
- Withdrawal: sel_in 1→2→1 before any frame_end. Required: busy rises, then falls, and mode stays 1 with no mode_changed.
- Invalid selection: sel_in=0 and sel_in=3 with NUM_MODES=2 across several frame_ends. Required: state stays IDLE and mode is unchanged.
- Coincident events:
  - In ARMED(pending=2), sel_in→1 and frame_end in the same cycle. Required: IDLE, mode=1.
  - In FLASH, new request on the terminal frame_end. Required: ARMED, led_ack=0.
- Reset mid-operation: assert reset while ARMED and again while FLASH. Required: mode=1, led_ack=0, state IDLE on the cycle after reset, with no strobe.
